sfx_scheduler: RTL and testbench
================================

# sfx_scheduler

Sound-effect scheduler that sits between the game-logic register file and the audio codec's Avalon-ST left/right sample sinks. It accepts one-cycle trigger pulses for several effects, arbitrates them by fixed priority with preemption and queuing, and sequences reads from a single shared synchronous sample ROM. Samples are paced at a fixed rate, and each sample is streamed to both codec channels with per-channel valid/ready handshakes. Zero samples are emitted whenever no effect is playing.

## Interface
- `NUM_SFX`, default 4: number of effects. Effect IDs run 0..NUM_SFX-1, and a higher ID has higher priority (0 = pellet, 1 = ghost eaten, 2 = death, 3 = game over).
- `ADDR_W`, default 16: sample ROM address width.
- `SAMPLE_PERIOD`, default 1042: clk cycles per sample (50 MHz / 48 kHz). Must be at least 4.
- `clk` in 1: 50 MHz system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `sfx_req` in NUM_SFX: one-cycle trigger pulses, one bit per effect ID.
- `sfx_stop` in 1: abort the active effect and clear all pending requests.
- `mute` in 1: force streamed data to 0. ROM sequencing continues unchanged.
- `rom_addr` out ADDR_W: registered address to the shared sample ROM.
- `rom_data` in 16: ROM read data, valid the cycle after `rom_addr` is presented.
- `L_READY` / `R_READY` in 1: codec sink ready, one per channel.
- `L_DATA` / `R_DATA` out 16: sample data, one per channel.
- `L_VALID` / `R_VALID` out 1: sample valid, one per channel.
- `busy` out 1: high while an effect is active.
- `active_id` out clog2(NUM_SFX): ID of the active effect. Holds its last value when idle.
- `underrun` out 1: sticky flag; set when a sample is dropped, cleared only by reset.

## Operation
- **Tick counter**
  - Free-running; counts 0..SAMPLE_PERIOD-1 and wraps.
  - `tick` is asserted when the count equals SAMPLE_PERIOD-1.
- **Request handling**
  - `sfx_req` bits are ORed into a `pending` register every cycle.
  - `sfx_stop` clears `pending`, `busy` and the sample index. If `sfx_stop` and `sfx_req` are high in the same cycle, stop wins.
- **Arbitration (evaluated at each tick)**
  - Let `win` be the highest set bit of `pending`.
  - Idle with `win` present: start `win` at index 0 and clear its pending bit.
  - Active with `win` > `active_id`: preempt. The preempted effect is dropped, not resumed.
  - A request for the active ID restarts that effect at index 0.
  - Lower-priority pending bits stay queued.
- **FSM states**
  - WAIT_TICK: on `tick`, perform arbitration. If active, drive `rom_addr` = BASE[id] + index, then go to READ.
  - READ: go to LATCH.
  - LATCH: capture `rom_data` (or 0 when idle or `mute`) into both DATA registers, assert both VALIDs, go to STREAM.
  - STREAM: each channel's VALID drops on the cycle after its READY&VALID handshake. When both channels have been accepted, go to WAIT_TICK.
  - STREAM, `tick` arrives with a channel still unaccepted: set `underrun`, deassert both VALIDs and continue as WAIT_TICK in that same cycle.
- **Index advance and end of effect**
  - The index advances at LATCH.
  - When index = LEN[id]-1 has been latched, `busy` drops. The next tick arbitrates the remaining pending bits.
- **Arithmetic**
  - The index is ADDR_W bits.
  - BASE + index never wraps; package constants guarantee BASE + LEN ≤ 2^ADDR_W.

## Timing
- **Reset values:** `rom_addr` 0, `L_DATA`/`R_DATA` 0, `L_VALID`/`R_VALID` 0, `busy` 0, `active_id` 0, `underrun` 0. Tick counter 0, `pending` 0, FSM in WAIT_TICK.
- **Sample latency:** DATA and VALID are asserted 2 cycles after the tick cycle.
- **Request-to-start latency:** a request starts playback at the first tick strictly after the request cycle. The first sample appears on VALID 2 cycles after that tick.
- **Held data:** DATA is held stable while VALID is high.
- **Reset mid-stream:** reset deasserts VALID asynchronously. No partial handshake persists.
- **Mute:** a change of `mute` takes effect at the next LATCH.

## Structure
- **Package `sfx_pkg`** holds:
  - SFX ID localparams (`SFX_PELLET`, `SFX_GHOST`, `SFX_DEATH`, `SFX_GAMEOVER`);
  - `SFX_BASE[]` and `SFX_LEN[]` constant arrays (pellet base 0, length 17555; game over base 17555, length 16533);
  - the FSM state enum `sfx_state_t`.
- **Sub-module `sfx_prio_enc`:** a parameterised highest-set-bit priority encoder with `found` and `idx` outputs.

## Test plan
- **Single effect:** SAMPLE_PERIOD=8, LEN[0]=4, ROM holds address-as-data.
  - Stimulus: pulse `sfx_req[0]`, with READY held high on both channels.
  - Required response: 4 handshakes per channel carrying BASE[0]+0..3, then `busy`=0, then zero samples.
- **Preemption and queuing:** start effect 0, then pulse `sfx_req[3]` mid-effect, then pulse `sfx_req[1]`.
  - Required response: at the next tick, `active_id`=3 and index restarts at 0.
  - After effect 3 ends, effect 1 plays.
  - Effect 0 is never resumed.
- **Simultaneous requests:** pulse `sfx_req`=4'b0101 in one cycle.
  - Required response: effect 2 plays first, then effect 0.
- **Backpressure:** hold `R_READY`=0 for 3 cycles after VALID rises.
  - Required response: `L_VALID` drops after its handshake, `R_DATA` stays stable, and R is accepted late with no underrun.
  - With `R_READY` held low past the next tick: `underrun`=1 and the FSM continues.
- **Stop and mute:**
  - Asserting `sfx_stop` while `sfx_req[2]` pulses in the same cycle leaves `busy`=0 and `pending`=0.
  - With `mute`=1 during effect 0: DATA is 0 while `rom_addr` still advances.
- **Async reset mid-STREAM:** assert `reset_n`=0 asynchronously while in STREAM.
  - Required response: all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared constants and types for the sound-effect scheduler: effect IDs,
// sample ROM layout and FSM state encoding.
package sfx_pkg;

  localparam int SFX_NUM    = 4;
  localparam int SFX_ADDR_W = 16;

  localparam int SFX_PELLET   = 0;
  localparam int SFX_GHOST    = 1;
  localparam int SFX_DEATH    = 2;
  localparam int SFX_GAMEOVER = 3;

  typedef logic [SFX_NUM-1:0][SFX_ADDR_W-1:0] sfx_tbl_t;

  // Element order is {GAMEOVER, DEATH, GHOST, PELLET}; every BASE + LEN fits in 16 bits.
  localparam sfx_tbl_t SFX_BASE = {16'd17555, 16'd40088, 16'd34088, 16'd0};
  localparam sfx_tbl_t SFX_LEN  = {16'd16533, 16'd20000, 16'd6000,  16'd17555};

  typedef enum logic [1:0] {
    ST_WAIT_TICK = 2'd0,
    ST_READ      = 2'd1,
    ST_LATCH     = 2'd2,
    ST_STREAM    = 2'd3
  } sfx_state_t;

endpackage

// File: rtl/sfx_scheduler_if.sv
// Sample ROM port plus the left/right Avalon-ST sample streams toward the codec.
interface sfx_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [15:0]       L_DATA;
  logic              L_VALID;
  logic              L_READY;
  logic [15:0]       R_DATA;
  logic              R_VALID;
  logic              R_READY;

  modport master (
    output rom_addr, L_DATA, L_VALID, R_DATA, R_VALID,
    input  rom_data, L_READY, R_READY
  );

  modport slave (
    input  rom_addr, L_DATA, L_VALID, R_DATA, R_VALID,
    output rom_data, L_READY, R_READY
  );
endinterface

// File: rtl/sfx_prio_enc.sv
// Highest-set-bit priority encoder; idx is only meaningful when found is high.
module sfx_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: fixed-priority arbitration with preemption, paced
// reads from a shared synchronous sample ROM, and dual-channel sample streaming.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_SFX       = 4,
  parameter int ADDR_W        = 16,
  parameter int SAMPLE_PERIOD = 1042,
  parameter logic [NUM_SFX-1:0][ADDR_W-1:0] BASE = SFX_BASE,
  parameter logic [NUM_SFX-1:0][ADDR_W-1:0] LEN  = SFX_LEN
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_SFX-1:0]         sfx_req,
  input  logic                       sfx_stop,
  input  logic                       mute,
  sfx_scheduler_if.master            bus,
  output logic                       busy,
  output logic [$clog2(NUM_SFX)-1:0] active_id,
  output logic                       underrun
);

  localparam int ID_W  = $clog2(NUM_SFX);
  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SFX-1:0] pending_q, pending_d;
  sfx_state_t         state_q, state_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [15:0]        l_data_q, l_data_d, r_data_q, r_data_d;
  logic               l_valid_q, l_valid_d, r_valid_q, r_valid_d;
  logic               underrun_q, underrun_d;

  logic               tick;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic               l_open, r_open;
  logic               arb_now, start;

  sfx_prio_enc #(.N(NUM_SFX), .IDX_W(ID_W)) u_prio (
    .vec   (pending_q),
    .found (win_found),
    .idx   (win_idx)
  );

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | sfx_req;
    busy_d     = busy_q;
    id_d       = id_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    l_data_d   = l_data_q;
    r_data_d   = r_data_q;
    l_valid_d  = l_valid_q;
    r_valid_d  = r_valid_q;
    underrun_d = underrun_q;
    start      = 1'b0;

    l_open  = l_valid_q & ~bus.L_READY;
    r_open  = r_valid_q & ~bus.R_READY;
    // A tick that lands in STREAM is handled exactly as in WAIT_TICK, so no sample slot is lost.
    arb_now = tick && (state_q == ST_WAIT_TICK || state_q == ST_STREAM);

    case (state_q)
      ST_READ: state_d = ST_LATCH;
      ST_LATCH: begin
        l_data_d  = (busy_q && !mute) ? bus.rom_data : 16'd0;
        r_data_d  = (busy_q && !mute) ? bus.rom_data : 16'd0;
        l_valid_d = 1'b1;
        r_valid_d = 1'b1;
        state_d   = ST_STREAM;
        if (busy_q) begin
          if (idx_q == LEN[id_q] - ADDR_ONE) busy_d = 1'b0;
          else                               idx_d  = idx_q + ADDR_ONE;
        end
      end
      ST_STREAM: begin
        l_valid_d = l_open;
        r_valid_d = r_open;
        if (!l_open && !r_open) state_d = ST_WAIT_TICK;
      end
      default: ;
    endcase

    if (arb_now) begin
      if (l_open || r_open) underrun_d = 1'b1;
      l_valid_d = 1'b0;
      r_valid_d = 1'b0;
      state_d   = ST_READ;
      // Equal ID restarts the active effect; a lower ID stays queued in pending.
      start = win_found && !sfx_stop && (!busy_q || win_idx >= id_q);
      if (start) begin
        id_d               = win_idx;
        idx_d              = '0;
        busy_d             = 1'b1;
        pending_d[win_idx] = sfx_req[win_idx];
        rom_addr_d         = BASE[win_idx];
      end else if (busy_q) begin
        rom_addr_d = BASE[id_q] + idx_q;
      end
    end

    if (sfx_stop) begin
      pending_d = '0;
      busy_d    = 1'b0;
      idx_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      pending_q  <= '0;
      state_q    <= ST_WAIT_TICK;
      busy_q     <= 1'b0;
      id_q       <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      l_data_q   <= '0;
      r_data_q   <= '0;
      l_valid_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      l_data_q   <= l_data_d;
      r_data_q   <= r_data_d;
      l_valid_q  <= l_valid_d;
      r_valid_q  <= r_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.L_DATA   = l_data_q;
  assign bus.R_DATA   = r_data_q;
  assign bus.L_VALID  = l_valid_q;
  assign bus.R_VALID  = r_valid_q;
  assign busy         = busy_q;
  assign active_id    = id_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with short effects, an address-as-data ROM
// and SAMPLE_PERIOD=8.
module tb_sfx_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sfx_req = 4'b0000;
  logic       sfx_stop = 1'b0;
  logic       mute = 1'b0;
  logic       busy, underrun;
  logic [1:0] active_id;

  int n_chk = 0;
  int n_err = 0;

  bit          collect = 1'b0;
  int          l_hs = 0;
  logic [15:0] lq[$];
  logic [15:0] rq[$];

  typedef struct packed {
    logic [3:0]       req;
    logic             mute;
    logic [3:0]       n;
    logic [5:0][15:0] exp;
    logic [15:0]      last_addr;
  } vec_t;

  vec_t tbl [5];

  sfx_scheduler_if #(.ADDR_W(16)) bus ();

  sfx_scheduler #(
    .NUM_SFX       (4),
    .ADDR_W        (16),
    .SAMPLE_PERIOD (8),
    .BASE          ({16'h0300, 16'h0200, 16'h0100, 16'h0010}),
    .LEN           ({16'd3, 16'd2, 16'd2, 16'd4})
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sfx_req   (sfx_req),
    .sfx_stop  (sfx_stop),
    .mute      (mute),
    .bus       (bus),
    .busy      (busy),
    .active_id (active_id),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= bus.rom_addr;

  always @(negedge clk) begin
    if (collect) begin
      if (bus.L_VALID && bus.L_READY) begin
        l_hs = l_hs + 1;
        if (bus.L_DATA != 16'd0) lq.push_back(bus.L_DATA);
      end
      if (bus.R_VALID && bus.R_READY && bus.R_DATA != 16'd0) rq.push_back(bus.R_DATA);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] r);
    sfx_req = r;
    cyc(1);
    sfx_req = 4'b0000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_lvalid(input string nm);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.L_VALID && w < 30);
    chk(nm, bus.L_VALID, 1);
  endtask

  initial begin
    int          w;
    int          np;
    logic [15:0] held;
    logic [15:0] tail [5];

    bus.L_READY = 1'b1;
    bus.R_READY = 1'b1;

    tbl[0] = '{req: 4'b0001, mute: 1'b0, n: 4'd4,
               exp: {16'h0, 16'h0, 16'h0013, 16'h0012, 16'h0011, 16'h0010}, last_addr: 16'h0013};
    tbl[1] = '{req: 4'b0101, mute: 1'b0, n: 4'd6,
               exp: {16'h0013, 16'h0012, 16'h0011, 16'h0010, 16'h0201, 16'h0200}, last_addr: 16'h0013};
    tbl[2] = '{req: 4'b1000, mute: 1'b0, n: 4'd3,
               exp: {16'h0, 16'h0, 16'h0, 16'h0302, 16'h0301, 16'h0300}, last_addr: 16'h0302};
    tbl[3] = '{req: 4'b0001, mute: 1'b1, n: 4'd0,
               exp: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, last_addr: 16'h0013};
    tbl[4] = '{req: 4'b0110, mute: 1'b0, n: 4'd4,
               exp: {16'h0, 16'h0, 16'h0101, 16'h0100, 16'h0201, 16'h0200}, last_addr: 16'h0101};

    // Reset state
    do_reset();
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_l_data", bus.L_DATA, 0);
    chk("rst_r_data", bus.R_DATA, 0);
    chk("rst_l_valid", bus.L_VALID, 0);
    chk("rst_r_valid", bus.R_VALID, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_underrun", underrun, 0);

    // Table-driven effects: single, simultaneous, highest, muted, queued
    for (int r = 0; r < 5; r++) begin
      lq.delete();
      rq.delete();
      l_hs    = 0;
      mute    = tbl[r].mute;
      collect = 1'b1;
      pulse(tbl[r].req);
      cyc(80);
      collect = 1'b0;
      mute    = 1'b0;
      chk($sformatf("row%0d_l_count", r), lq.size(), tbl[r].n);
      chk($sformatf("row%0d_r_count", r), rq.size(), tbl[r].n);
      for (int k = 0; k < int'(tbl[r].n); k++) begin
        chk($sformatf("row%0d_l_data%0d", r, k), (k < lq.size()) ? lq[k] : 32'hFFFF_FFFF, tbl[r].exp[k]);
        chk($sformatf("row%0d_r_data%0d", r, k), (k < rq.size()) ? rq[k] : 32'hFFFF_FFFF, tbl[r].exp[k]);
      end
      chk($sformatf("row%0d_samples_flowing", r), l_hs >= 8, 1);
      chk($sformatf("row%0d_busy_end", r), busy, 0);
      chk($sformatf("row%0d_rom_addr_end", r), bus.rom_addr, tbl[r].last_addr);
    end

    // Preemption of effect 0 by 3, with 1 queued behind it
    do_reset();
    lq.delete();
    rq.delete();
    collect = 1'b1;
    pulse(4'b0001);
    w = 0;
    do begin @(negedge clk); w++; end while (!busy && w < 30);
    chk("pre_e0_started", busy, 1);
    cyc(10);
    pulse(4'b1000);
    cyc(3);
    pulse(4'b0010);
    w = 0;
    do begin @(negedge clk); w++; end while (!(busy && active_id == 2'd3) && w < 30);
    chk("pre_active_id3", active_id, 3);
    cyc(90);
    collect = 1'b0;
    np = 0;
    while (np < lq.size() && lq[np] >= 16'h0010 && lq[np] <= 16'h0013) np++;
    chk("pre_e0_truncated", (np >= 1 && np <= 3), 1);
    for (int k = 0; k < np; k++) chk($sformatf("pre_e0_data%0d", k), lq[k], 16'h0010 + k);
    tail = '{16'h0300, 16'h0301, 16'h0302, 16'h0100, 16'h0101};
    chk("pre_l_count", lq.size(), np + 5);
    chk("pre_r_count", rq.size(), np + 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("pre_tail%0d", k), (np + k < lq.size()) ? lq[np + k] : 32'hFFFF_FFFF, tail[k]);
    chk("pre_idle_end", busy, 0);

    // Backpressure on R, then an underrun
    do_reset();
    bus.R_READY = 1'b0;
    pulse(4'b0001);
    wait_lvalid("bp_valid_rise");
    held = bus.R_DATA;
    chk("bp_first_data", held, 16'h0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_l_valid_drop%0d", k), bus.L_VALID, 0);
      chk($sformatf("bp_r_valid_hold%0d", k), bus.R_VALID, 1);
      chk($sformatf("bp_r_data_stable%0d", k), bus.R_DATA, held);
    end
    @(posedge clk); #1;
    bus.R_READY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_r_accepted", bus.R_VALID, 0);
    chk("bp_no_underrun", underrun, 0);
    @(posedge clk); #1;
    bus.R_READY = 1'b0;
    wait_lvalid("ur_valid_rise");
    repeat (10) @(negedge clk);
    chk("ur_underrun_set", underrun, 1);
    @(posedge clk); #1;
    bus.R_READY = 1'b1;
    wait_lvalid("ur_fsm_continues");
    chk("ur_next_data", bus.L_DATA, 16'h0013);
    chk("ur_underrun_sticky", underrun, 1);

    // Stop wins over a same-cycle request
    do_reset();
    pulse(4'b0001);
    w = 0;
    do begin @(negedge clk); w++; end while (!busy && w < 30);
    chk("stop_e0_started", busy, 1);
    @(posedge clk); #1;
    sfx_stop = 1'b1;
    sfx_req  = 4'b0100;
    cyc(1);
    sfx_stop = 1'b0;
    sfx_req  = 4'b0000;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_pending", dut.pending_q, 0);
    repeat (20) @(negedge clk);
    chk("stop_stays_idle", busy, 0);

    // Asynchronous reset in the middle of STREAM
    do_reset();
    bus.R_READY = 1'b0;
    pulse(4'b0001);
    wait_lvalid("ar_in_stream");
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_l_valid", bus.L_VALID, 0);
    chk("ar_r_valid", bus.R_VALID, 0);
    chk("ar_l_data", bus.L_DATA, 0);
    chk("ar_r_data", bus.R_DATA, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rom_addr", bus.rom_addr, 0);
    cyc(2);
    reset_n = 1'b1;
    bus.R_READY = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
